// File: rtl/gate_truth_checker.sv
// Cycle-accurate exhaustive checker for a 2-input gate: walks vectors 00..11, samples after a settle window, flags mismatches.
// Optional GATE_CHK_FIRST_FAIL_EN adds first_fail_vld/first_fail_idx reporting of the first mismatching vector.
module gate_truth_checker #(
  parameter logic [3:0] TRUTH_TABLE   = 4'b1110,
  parameter int         SETTLE_CYCLES = 2,
  parameter int         ERR_W         = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dut_out,
  output logic             dut_in1,
  output logic             dut_in2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
`ifdef GATE_CHK_FIRST_FAIL_EN
  output logic             first_fail_vld,
  output logic [1:0]       first_fail_idx,
`endif
  output logic [3:0]       fail_vec
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t           state, state_nx;
  logic [1:0]       idx, idx_nx;
  logic [7:0]       cnt, cnt_nx;
  logic             dut_in1_nx, dut_in2_nx;
  logic             busy_nx, done_nx, pass_nx;
  logic [ERR_W-1:0] err_count_nx;
  logic [3:0]       fail_vec_nx, fail_vec_upd;
  logic             mismatch;
`ifdef GATE_CHK_FIRST_FAIL_EN
  logic             first_fail_vld_nx;
  logic [1:0]       first_fail_idx_nx;
`endif

  // Saturating increment keeps the counter pinned at its maximum.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    if (&v) return v;
    return v + ERR_W'(1);
  endfunction

  always_comb begin
    mismatch     = (dut_out != TRUTH_TABLE[idx]);
    fail_vec_upd = fail_vec;
    if (mismatch) fail_vec_upd[idx] = 1'b1;
  end

  always_comb begin
    state_nx     = state;
    idx_nx       = idx;
    cnt_nx       = cnt;
    dut_in1_nx   = dut_in1;
    dut_in2_nx   = dut_in2;
    busy_nx      = busy;
    done_nx      = done;
    pass_nx      = pass;
    err_count_nx = err_count;
    fail_vec_nx  = fail_vec;
`ifdef GATE_CHK_FIRST_FAIL_EN
    first_fail_vld_nx = first_fail_vld;
    first_fail_idx_nx = first_fail_idx;
`endif

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx     = DRIVE;
          idx_nx       = 2'd0;
          cnt_nx       = 8'd0;
          dut_in1_nx   = 1'b0;
          dut_in2_nx   = 1'b0;
          busy_nx      = 1'b1;
          done_nx      = 1'b0;
          pass_nx      = 1'b0;
          err_count_nx = '0;
          fail_vec_nx  = 4'b0000;
`ifdef GATE_CHK_FIRST_FAIL_EN
          first_fail_vld_nx = 1'b0;
          first_fail_idx_nx = 2'd0;
`endif
        end
      end

      DRIVE: begin
        cnt_nx   = SETTLE_LOAD;
        state_nx = SETTLE;
      end

      SETTLE: begin
        if (cnt == 8'd0) state_nx = SAMPLE;
        else             cnt_nx   = cnt - 8'd1;
      end

      SAMPLE: begin
        fail_vec_nx = fail_vec_upd;
        if (mismatch) begin
          err_count_nx = sat_inc(err_count);
`ifdef GATE_CHK_FIRST_FAIL_EN
          if (!first_fail_vld) begin
            first_fail_vld_nx = 1'b1;
            first_fail_idx_nx = idx;
          end
`endif
        end
        if (idx == 2'd3) begin
          // pass derives from the fail map so a saturated count cannot hide a miss
          state_nx   = DONE;
          busy_nx    = 1'b0;
          done_nx    = 1'b1;
          pass_nx    = ~|fail_vec_upd;
          dut_in1_nx = 1'b0;
          dut_in2_nx = 1'b0;
        end else begin
          state_nx   = DRIVE;
          idx_nx     = idx + 2'd1;
          {dut_in1_nx, dut_in2_nx} = idx + 2'd1;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 2'd0;
      cnt       <= 8'd0;
      dut_in1   <= 1'b0;
      dut_in2   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= 4'b0000;
`ifdef GATE_CHK_FIRST_FAIL_EN
      first_fail_vld <= 1'b0;
      first_fail_idx <= 2'd0;
`endif
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      cnt       <= cnt_nx;
      dut_in1   <= dut_in1_nx;
      dut_in2   <= dut_in2_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      pass      <= pass_nx;
      err_count <= err_count_nx;
      fail_vec  <= fail_vec_nx;
`ifdef GATE_CHK_FIRST_FAIL_EN
      first_fail_vld <= first_fail_vld_nx;
      first_fail_idx <= first_fail_idx_nx;
`endif
    end
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker: OR/AND/NOR gate models, mid-run start and reset, short settle variant.
module tb_gate_truth_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       start_f = 1'b0;
  int         gsel = 0;
  logic       dut_out, dut_out_f;
  logic       dut_in1, dut_in2, busy, done, pass;
  logic [1:0] err_count;
  logic [3:0] fail_vec;
  logic       dut_in1_f, dut_in2_f, busy_f, done_f, pass_f;
  logic [1:0] err_count_f;
  logic [3:0] fail_vec_f;
`ifdef GATE_CHK_FIRST_FAIL_EN
  logic       ffv, ffv_f;
  logic [1:0] ffi, ffi_f;
`endif

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // gsel: 0 = OR, 1 = AND, 2 = NOR
  always_comb begin
    case (gsel)
      1:       dut_out = dut_in1 & dut_in2;
      2:       dut_out = ~(dut_in1 | dut_in2);
      default: dut_out = dut_in1 | dut_in2;
    endcase
  end
  assign dut_out_f = dut_in1_f | dut_in2_f;

  gate_truth_checker u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_out(dut_out),
    .dut_in1(dut_in1), .dut_in2(dut_in2), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count),
`ifdef GATE_CHK_FIRST_FAIL_EN
    .first_fail_vld(ffv), .first_fail_idx(ffi),
`endif
    .fail_vec(fail_vec)
  );

  gate_truth_checker #(.TRUTH_TABLE(4'b1110), .SETTLE_CYCLES(1), .ERR_W(2)) u_fast (
    .clk(clk), .rst_n(rst_n), .start(start_f), .dut_out(dut_out_f),
    .dut_in1(dut_in1_f), .dut_in2(dut_in2_f), .busy(busy_f), .done(done_f),
    .pass(pass_f), .err_count(err_count_f),
`ifdef GATE_CHK_FIRST_FAIL_EN
    .first_fail_vld(ffv_f), .first_fail_idx(ffi_f),
`endif
    .fail_vec(fail_vec_f)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One run of the main checker; optionally pokes start during vector 2 settle.
  task automatic run_main(input string tag, input int g, input logic [3:0] efail,
                          input logic [1:0] eerr, input logic epass, input bit poke);
    gsel = g;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk({tag, "_acc_busy"}, 8'(busy), 8'd1);
    chk({tag, "_acc_vec"}, 8'({dut_in1, dut_in2}), 8'd0);
    for (int e = 1; e <= 16; e++) begin
      if (poke && e == 10) start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      if (e < 16) begin
        chk($sformatf("%s_vec_e%0d", tag, e), 8'({dut_in1, dut_in2}), 8'(e / 4));
        chk($sformatf("%s_done_e%0d", tag, e), 8'(done), 8'd0);
        chk($sformatf("%s_busy_e%0d", tag, e), 8'(busy), 8'd1);
      end else begin
        chk({tag, "_done"}, 8'(done), 8'd1);
        chk({tag, "_busy"}, 8'(busy), 8'd0);
        chk({tag, "_pass"}, 8'(pass), 8'(epass));
        chk({tag, "_err"}, 8'(err_count), 8'(eerr));
        chk({tag, "_fvec"}, 8'(fail_vec), 8'(efail));
        chk({tag, "_endvec"}, 8'({dut_in1, dut_in2}), 8'd0);
`ifdef GATE_CHK_FIRST_FAIL_EN
        chk({tag, "_ffv"}, 8'(ffv), 8'(|efail));
        chk({tag, "_ffi"}, 8'(ffi), efail[0] ? 8'd0 : efail[1] ? 8'd1 : efail[2] ? 8'd2 : efail[3] ? 8'd3 : 8'd0);
`endif
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_pass", 8'(pass), 8'd0);
    chk("rst_err", 8'(err_count), 8'd0);
    chk("rst_fvec", 8'(fail_vec), 8'd0);
    chk("rst_vec", 8'({dut_in1, dut_in2}), 8'd0);
    chk("rst_fast_busy", 8'(busy_f), 8'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", 8'(busy), 8'd0);

    run_main("or", 0, 4'b0000, 2'd0, 1'b1, 1'b0);
    run_main("and", 1, 4'b0110, 2'd2, 1'b0, 1'b0);
    run_main("nor", 2, 4'b1111, 2'd3, 1'b0, 1'b0);
    run_main("poke", 2, 4'b1111, 2'd3, 1'b0, 1'b1);

    // restart from DONE clears results at the accept edge
    gsel = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("rs_done", 8'(done), 8'd0);
    chk("rs_busy", 8'(busy), 8'd1);
    chk("rs_err", 8'(err_count), 8'd0);
    chk("rs_fvec", 8'(fail_vec), 8'd0);
    chk("rs_vec", 8'({dut_in1, dut_in2}), 8'd0);
    repeat (16) @(posedge clk);
    #1;
    chk("rs_end_done", 8'(done), 8'd1);
    chk("rs_end_pass", 8'(pass), 8'd1);

    // reset during vector 1 settle aborts the run
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mr_vec1", 8'({dut_in1, dut_in2}), 8'd1);
    rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    chk("mr_busy", 8'(busy), 8'd0);
    chk("mr_vec", 8'({dut_in1, dut_in2}), 8'd0);
    chk("mr_done", 8'(done), 8'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("mr_late_done", 8'(done), 8'd0);
    chk("mr_late_busy", 8'(busy), 8'd0);

    // reset wins over start in the same cycle
    @(negedge clk); start = 1'b1; start_f = 1'b1; rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rs_vs_st_busy", 8'(busy), 8'd0);
    chk("rs_vs_st_fbusy", 8'(busy_f), 8'd0);
    @(negedge clk); rst_n = 1'b1; start = 1'b0; start_f = 1'b0;
    @(posedge clk); #1;
    chk("rs_vs_st_busy2", 8'(busy), 8'd0);

    // SETTLE_CYCLES=1 instance: vectors held 3 cycles, done at N+12
    @(negedge clk); start_f = 1'b1;
    @(posedge clk); #1; start_f = 1'b0;
    chk("f_acc_busy", 8'(busy_f), 8'd1);
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      if (e < 12) begin
        chk($sformatf("f_vec_e%0d", e), 8'({dut_in1_f, dut_in2_f}), 8'(e / 3));
        chk($sformatf("f_done_e%0d", e), 8'(done_f), 8'd0);
      end
    end
    chk("f_done", 8'(done_f), 8'd1);
    chk("f_pass", 8'(pass_f), 8'd1);
    chk("f_err", 8'(err_count_f), 8'd0);
    chk("f_fvec", 8'(fail_vec_f), 8'd0);
    chk("f_busy", 8'(busy_f), 8'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/gate_truth_checker.md
Name: gate_truth_checker

Overview:
Synthesizable self-checking response end for 2-input logic-gate blocks (OR, AND, XOR, ...).
- Drives the two DUT inputs through all four input combinations in order.
- After each vector, waits a programmable settle time, samples the DUT output and compares it against a parameterized truth table.
- Reports pass/fail, an error count and a per-vector fail map.
- Sits beside a gate instance in on-chip BIST wrappers and in benches that need a cycle-accurate checker instead of delay-based stimulus.

Parameters:
TRUTH_TABLE, 4'b1110, expected DUT output; bit index = {in1,in2}; default = OR
SETTLE_CYCLES, 2, cycles the vector is held before sampling; legal range 1..255
ERR_W, 2, width of err_count; saturates at 2**ERR_W-1

Ports:
clk  input  1  clock; all logic on the rising edge
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
start  input  1  begin a check run; accepted only in IDLE or DONE
dut_out  input  1  output of the gate under test
dut_in1  output  1  drives DUT in1 (vector index bit 1)
dut_in2  output  1  drives DUT in2 (vector index bit 0)
busy  output  1  high while a run is in progress
done  output  1  high while in DONE (level, not pulse)
pass  output  1  valid when done=1; 1 iff fail_vec==0
err_count  output  ERR_W  number of mismatching vectors, saturating
fail_vec  output  4  bit k set if vector k mismatched

Behaviour:
- All outputs are registered. Reset values: dut_in1=0, dut_in2=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, state=IDLE, idx=0, settle counter=0.
- rst_n=0 at an edge forces the reset values at that edge regardless of state, including mid-run. Reset beats start in the same cycle.
- State machine:
  - IDLE: busy=0, done=0. start=1 -> idx=0, err_count=0, fail_vec=0, {dut_in1,dut_in2}=2'b00, busy=1, go DRIVE.
  - DRIVE: 1 cycle. Load settle counter with SETTLE_CYCLES-1, go SETTLE.
  - SETTLE: hold the vector. Counter==0 -> SAMPLE, else decrement.
  - SAMPLE: 1 cycle; compare dut_out to TRUTH_TABLE[idx] combinationally. On mismatch: fail_vec[idx]<=1; err_count<=err_count+1 unless already at max.
    - idx==3 -> DONE: busy=0, done=1, pass=~|(updated fail_vec), {dut_in1,dut_in2}=2'b00.
    - else idx<=idx+1, drive the new idx on dut_in1/dut_in2 at the same edge, go DRIVE.
  - DONE: results held stable. start=1 -> same action as from IDLE (results cleared at the accept edge, done drops).
- The vector is held constant for SETTLE_CYCLES+2 cycles. Vector k appears at accept edge N + k*(SETTLE_CYCLES+2). done rises at edge N + 4*(SETTLE_CYCLES+2).
- start while busy=1 is ignored; no effect on timing or results.
- pass is computed from fail_vec, never from err_count, so saturation cannot mask a failure.

Optional Feature:
GATE_CHK_FIRST_FAIL_EN
- Defined:
  - Adds outputs first_fail_vld (1) and first_fail_idx (2), both reset to 0 and cleared at the start-accept edge.
  - On the first mismatch of a run: first_fail_vld<=1 and first_fail_idx<=idx. Later mismatches do not change them.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
1. OR DUT, defaults, 1-cycle start pulse at edge N -> dut_in sequence 00,01,10,11, each held exactly 4 cycles; done=1 at N+16; pass=1, err_count=0, fail_vec=4'b0000.
2. AND DUT, TRUTH_TABLE=4'b1110 -> fail_vec=4'b0110, err_count=2, pass=0; with macro: first_fail_vld=1, first_fail_idx=1.
3. NOR DUT (every vector wrong), ERR_W=2 -> err_count saturates at 3, fail_vec=4'b1111, pass=0.
4. start pulsed during vector 2 SETTLE -> ignored, done still at N+16. Then start in DONE -> at the accept edge done=0, busy=1, err_count/fail_vec cleared, vector 00 driven.
5. rst_n=0 for 1 cycle during vector 1 SETTLE -> at that edge busy=0, dut_in=00, state IDLE. done never asserts until a new start.
6. start=1 and rst_n=0 in the same cycle -> reset values held, busy stays 0. SETTLE_CYCLES=1 run with OR DUT -> done at N+12, pass=1.
